// File: rtl/ble_uart_tx.sv
// ble_uart_tx
// 8N1 UART transmitter (LSB first) that drives the BLE module's RX pin.
// Bytes are accepted through a valid/ready handshake into a small circular
// FIFO. They are then serialised back-to-back, with all bit timing taken from
// a single-clock baud counter.
//
// Ports:
//   sys_clk   in   system clock
//   rst_n     in   asynchronous active-low reset
//   tx_data   in   [7:0] byte to send
//   tx_valid  in   tx_data valid
//   tx_ready  out  FIFO can accept a byte (not full), combinational from count
//   ble_txd   out  serial line to the BLE module, idle high (registered)
//   tx_busy   out  FIFO non-empty or frame in progress (registered)
//   tx_done   out  one-cycle pulse after the last stop-bit cycle (registered)
module ble_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       ble_txd,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic [7:0]    shift_reg;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic          push;
  logic          pop;
  logic          bit_end;

  assign tx_ready = (count != FULL_COUNT);
  assign push     = tx_valid && tx_ready;
  assign bit_end  = (baud_cnt == BAUD_LAST);

  // The FSM takes the head byte either when it is idle, or at the end of a
  // stop bit so the next frame starts with no gap.
  assign pop = (count != '0) &&
               ((state == IDLE) || ((state == STOP) && bit_end));

  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + 1'b1;
    end else if (pop && !push) begin
      count_nxt = count - 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  // The pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_nxt;
    end
  end

  // tx_busy is computed from the next occupancy. This makes it fall on the
  // same edge that raises the final tx_done when nothing else is queued.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ble_txd   <= 1'b1;
      tx_done   <= 1'b0;
      tx_busy   <= 1'b0;
      shift_reg <= '0;
      baud_cnt  <= '0;
      bit_idx   <= '0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          ble_txd <= 1'b1;
          tx_busy <= (count_nxt != '0);
          if (pop) begin
            shift_reg <= mem[rd_ptr];
            baud_cnt  <= '0;
            ble_txd   <= 1'b0;
            tx_busy   <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          tx_busy <= 1'b1;
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            ble_txd  <= shift_reg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          tx_busy <= 1'b1;
          if (bit_end) begin
            baud_cnt  <= '0;
            shift_reg <= {1'b0, shift_reg[7:1]};
            bit_idx   <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
              ble_txd <= 1'b1;
              state   <= STOP;
            end else begin
              // shift_reg[1] becomes bit 0 after this edge's shift.
              ble_txd <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            tx_done  <= 1'b1;
            baud_cnt <= '0;
            if (pop) begin
              shift_reg <= mem[rd_ptr];
              ble_txd   <= 1'b0;
              tx_busy   <= 1'b1;
              state     <= START;
            end else begin
              tx_busy <= (count_nxt != '0);
              state   <= IDLE;
            end
          end else begin
            tx_busy  <= 1'b1;
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          ble_txd  <= 1'b1;
          baud_cnt <= '0;
          bit_idx  <= '0;
          tx_busy  <= (count_nxt != '0);
        end
      endcase
    end
  end

endmodule
